// File: rtl/sfp_ctrl_pkg.sv
// Shared types for the SFP tile sequencer.
// State encoding and activation-function codes.
package sfp_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PASS_WR = 3'd1,
      ACC_RD  = 3'd2,
      ACC_WR  = 3'd3,
      ACT_RD  = 3'd4,
      ACT_WR  = 3'd5,
      DONE    = 3'd6
   } state_t;

   localparam logic [1:0] ACT_RELU  = 2'b00;
   localparam logic [1:0] ACT_LEAKY = 2'b01;

endpackage

// File: rtl/sfp_addr_gen.sv
// Row/pass counters and PSUM address for one output tile.
// Address is base+row modulo 2^ADDR_W.
module sfp_addr_gen #(
   parameter int ADDR_W = 11,
   parameter int ROW_W  = 11,
   parameter int PASS_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              adv,
   input  logic [ADDR_W-1:0] base,
   input  logic [ROW_W-1:0]  num_rows,
   input  logic [PASS_W-1:0] eff_pass,
   output logic [ADDR_W-1:0] addr,
   output logic              row_last,
   output logic              pass_last
);

   logic [ROW_W-1:0]  row;
   logic [PASS_W-1:0] pass;

   assign row_last  = (row == num_rows - ROW_W'(1));
   assign pass_last = ({1'b0, pass} + (PASS_W+1)'(1)) == {1'b0, eff_pass};
   assign addr      = base + ADDR_W'(row);

   always_ff @(posedge clk) begin
      if (reset || load) begin
         row  <= '0;
         pass <= '0;
      end else if (adv) begin
         if (row_last) begin
            row  <= '0;
            pass <= pass + PASS_W'(1);
         end else begin
            row <= row + ROW_W'(1);
         end
      end
   end

endmodule

// File: rtl/sfp_ctrl.sv
// SFP tile sequencer: passthrough, accumulate and activation passes.
// Define SFP_LEAKY_EN to honour act_leaky; otherwise ReLU only.
module sfp_ctrl
   import sfp_ctrl_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int ROW_W  = 11,
   parameter int PASS_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [PASS_W-1:0] num_pass,
   input  logic [ROW_W-1:0]  num_rows,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              act_leaky,
   input  logic              ofifo_valid,
   output logic              ofifo_rd,
   output logic              sram_cen,
   output logic              sram_wen,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sfp_accum,
   output logic              sfp_passthrough,
   output logic [1:0]        sfp_actfunc,
   output logic              busy,
   output logic              done
);

   state_t            state, state_nx;
   logic [ROW_W-1:0]  cfg_rows;
   logic [ADDR_W-1:0] cfg_base;
   logic [PASS_W-1:0] cfg_pass;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        act_code;
   logic              load, row_adv, row_last, pass_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cfg_rows <= '0;
         cfg_base <= '0;
         cfg_pass <= '0;
      end else begin
         state <= state_nx;
         if (load) begin
            cfg_rows <= num_rows;
            cfg_base <= base_addr;
            cfg_pass <= (num_pass == '0) ? PASS_W'(1) : num_pass;
         end
      end
   end

`ifdef SFP_LEAKY_EN
   logic cfg_leaky;

   always_ff @(posedge clk) begin
      if (reset)
         cfg_leaky <= 1'b0;
      else if (load)
         cfg_leaky <= act_leaky;
   end

   assign act_code = cfg_leaky ? ACT_LEAKY : ACT_RELU;
`else
   logic unused_leaky;
   assign unused_leaky = act_leaky;
   assign act_code     = ACT_RELU;
`endif

   sfp_addr_gen #(
      .ADDR_W(ADDR_W),
      .ROW_W (ROW_W),
      .PASS_W(PASS_W)
   ) u_addr_gen (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .adv      (row_adv),
      .base     (cfg_base),
      .num_rows (cfg_rows),
      .eff_pass (cfg_pass),
      .addr     (addr),
      .row_last (row_last),
      .pass_last(pass_last)
   );

   always_comb begin
      state_nx        = state;
      load            = 1'b0;
      row_adv         = 1'b0;
      ofifo_rd        = 1'b0;
      sram_cen        = 1'b1;
      sram_wen        = 1'b1;
      sram_addr       = '0;
      sfp_accum       = 1'b0;
      sfp_passthrough = 1'b0;
      sfp_actfunc     = ACT_RELU;
      busy            = 1'b0;
      done            = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = PASS_WR;
            end
         end
         PASS_WR: begin
            busy      = 1'b1;
            sram_addr = addr;
            // An empty tile still spends one cycle here, with no SRAM access.
            if (cfg_rows == '0) begin
               state_nx = DONE;
            end else if (ofifo_valid) begin
               sfp_passthrough = 1'b1;
               sram_cen        = 1'b0;
               sram_wen        = 1'b0;
               ofifo_rd        = 1'b1;
               row_adv         = 1'b1;
               if (row_last)
                  state_nx = pass_last ? ACT_RD : ACC_RD;
            end
         end
         ACC_RD: begin
            busy      = 1'b1;
            sram_addr = addr;
            if (ofifo_valid) begin
               sram_cen = 1'b0;
               state_nx = ACC_WR;
            end
         end
         ACC_WR: begin
            busy      = 1'b1;
            sram_addr = addr;
            sfp_accum = 1'b1;
            sram_cen  = 1'b0;
            sram_wen  = 1'b0;
            ofifo_rd  = 1'b1;
            row_adv   = 1'b1;
            state_nx  = (row_last && pass_last) ? ACT_RD : ACC_RD;
         end
         ACT_RD: begin
            busy        = 1'b1;
            sram_addr   = addr;
            sfp_actfunc = act_code;
            sram_cen    = 1'b0;
            state_nx    = ACT_WR;
         end
         ACT_WR: begin
            busy        = 1'b1;
            sram_addr   = addr;
            sfp_actfunc = act_code;
            sram_cen    = 1'b0;
            sram_wen    = 1'b0;
            row_adv     = 1'b1;
            state_nx    = row_last ? DONE : ACT_RD;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Reset kills the SRAM port in the same cycle so no write lands.
      if (reset) begin
         ofifo_rd        = 1'b0;
         sram_cen        = 1'b1;
         sram_wen        = 1'b1;
         sram_addr       = '0;
         sfp_accum       = 1'b0;
         sfp_passthrough = 1'b0;
         sfp_actfunc     = ACT_RELU;
         busy            = 1'b0;
         done            = 1'b0;
      end
   end

endmodule

// File: tb/tb_sfp_ctrl.sv
// Directed bench for sfp_ctrl with an operation-list reference model.
// Honours SFP_LEAKY_EN the same way as the design build.
module tb_sfp_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, act_leaky, ofifo_valid;
   logic [3:0]  num_pass;
   logic [10:0] num_rows, base_addr;
   logic        ofifo_rd, sram_cen, sram_wen;
   logic [10:0] sram_addr;
   logic        sfp_accum, sfp_passthrough, busy, done;
   logic [1:0]  sfp_actfunc;

   sfp_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .num_pass       (num_pass),
      .num_rows       (num_rows),
      .base_addr      (base_addr),
      .act_leaky      (act_leaky),
      .ofifo_valid    (ofifo_valid),
      .ofifo_rd       (ofifo_rd),
      .sram_cen       (sram_cen),
      .sram_wen       (sram_wen),
      .sram_addr      (sram_addr),
      .sfp_accum      (sfp_accum),
      .sfp_passthrough(sfp_passthrough),
      .sfp_actfunc    (sfp_actfunc),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rd;
      logic        cen;
      logic        wen;
      logic [10:0] addr;
      logic        acc;
      logic        pt;
      logic [1:0]  af;
      logic        busy;
      logic        done;
   } obs_t;

   typedef struct {
      obs_t o;
      bit   ac;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        stage_q[$];
   logic [10:0] wr_q[$];
   int          checks = 0, errors = 0;
   int          tile_cyc, dut_done_cyc, rd_cnt, wr_cnt, cen_low_cnt;
   int          st_at, st_len, m_c, model_done;
   logic [1:0]  af_seen;
   obs_t        dut_o;

   always_comb
      dut_o = {ofifo_rd, sram_cen, sram_wen, sram_addr, sfp_accum,
               sfp_passthrough, sfp_actfunc, busy, done};

   function automatic bit vfun(int c);
      return !(c >= st_at && c < st_at + st_len);
   endfunction

   task automatic chk(string nm, int got, int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   // Cycle-by-cycle comparison against the model queue
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         obs_t a, x;
         e = exp_q.pop_front();
         tile_cyc++;
         a = dut_o;
         x = e.o;
         if (!e.ac) begin
            a.addr = '0;
            x.addr = '0;
         end
         checks++;
         if (a !== x) begin
            errors++;
            $display("FAIL trace cycle %0d: got rd/cen/wen/addr/acc/pt/af/busy/done=%b want %b",
                     tile_cyc, a, x);
         end
         if (done) dut_done_cyc = tile_cyc;
         if (ofifo_rd) rd_cnt++;
         if (!sram_cen) cen_low_cnt++;
         if (!sram_cen && !sram_wen) begin
            wr_cnt++;
            wr_q.push_back(sram_addr);
            if (!sfp_accum && !sfp_passthrough) af_seen = sfp_actfunc;
         end
      end
   end

   task automatic push_obs(obs_t o, bit ac);
      exp_t e;
      e.o  = o;
      e.ac = ac;
      stage_q.push_back(e);
      m_c++;
   endtask

   // One row operation; ops that consume OFIFO data wait out empty cycles.
   task automatic emit(logic rd, logic wen, logic acc, logic pt,
                       logic [1:0] af, logic [10:0] a, bit need_v);
      obs_t o;
      while (need_v && !vfun(m_c)) begin
         o      = '0;
         o.cen  = 1'b1;
         o.wen  = 1'b1;
         o.addr = a;
         o.busy = 1'b1;
         push_obs(o, 1'b1);
      end
      o      = '0;
      o.rd   = rd;
      o.wen  = wen;
      o.acc  = acc;
      o.pt   = pt;
      o.af   = af;
      o.addr = a;
      o.busy = 1'b1;
      push_obs(o, 1'b1);
   endtask

   task automatic model_tile(int np, int nr, int base, bit leaky);
      int         eff;
      logic [1:0] af;
      obs_t       o;
      eff = (np == 0) ? 1 : np;
`ifdef SFP_LEAKY_EN
      af = leaky ? 2'b01 : 2'b00;
`else
      af = 2'b00;
      if (leaky) af = 2'b00;
`endif
      stage_q.delete();
      m_c = 1;
      for (int r = 0; r < nr; r++)
         emit(1, 0, 0, 1, 2'b00, 11'(base + r), 1);
      for (int p = 1; p < eff; p++)
         for (int r = 0; r < nr; r++) begin
            emit(0, 1, 0, 0, 2'b00, 11'(base + r), 1);
            emit(1, 0, 1, 0, 2'b00, 11'(base + r), 0);
         end
      for (int r = 0; r < nr; r++) begin
         emit(0, 1, 0, 0, af, 11'(base + r), 0);
         emit(0, 0, 0, 0, af, 11'(base + r), 0);
      end
      o     = '0;
      o.cen = 1'b1;
      o.wen = 1'b1;
      if (nr == 0) begin
         o.busy = 1'b1;
         push_obs(o, 1'b0);
         o.busy = 1'b0;
      end
      o.done     = 1'b1;
      model_done = m_c;
      push_obs(o, 1'b0);
      o.done = 1'b0;
      push_obs(o, 1'b1);
   endtask

   task automatic run_tile(int np, int nr, int base, bit leaky,
                           int sat, int slen, int abort_at, int xstart_at);
      int n;
      st_at  = sat;
      st_len = slen;
      @(posedge clk); #1;
      num_pass    = 4'(np);
      num_rows    = 11'(nr);
      base_addr   = 11'(base);
      act_leaky   = leaky;
      start       = 1'b1;
      ofifo_valid = 1'b1;
      model_tile(np, nr, base, leaky);
      if (abort_at > 0)
         while (stage_q.size() > abort_at - 1) void'(stage_q.pop_back());
      n = stage_q.size();
      @(posedge clk); #1;
      start        = 1'b0;
      num_pass     = 4'd7;
      num_rows     = 11'd5;
      base_addr    = 11'h555;
      act_leaky    = ~leaky;
      tile_cyc     = 0;
      rd_cnt       = 0;
      wr_cnt       = 0;
      cen_low_cnt  = 0;
      dut_done_cyc = -1;
      af_seen      = 2'b11;
      wr_q.delete();
      ofifo_valid  = vfun(1);
      exp_q        = stage_q;
      for (int c = 2; c <= n; c++) begin
         @(posedge clk); #1;
         ofifo_valid = vfun(c);
         start       = (c == xstart_at);
      end
      if (abort_at > 0) begin
         @(posedge clk); #1;
         reset = 1'b1;
         start = 1'b1;
         @(negedge clk);
         chk("abort cen", int'(sram_cen), 1);
         chk("abort wen", int'(sram_wen), 1);
         chk("abort busy", int'(busy), 0);
         @(posedge clk); #1;
         reset = 1'b0;
         start = 1'b0;
         @(negedge clk);
         chk("post-abort cen", int'(sram_cen), 1);
         chk("post-abort wen", int'(sram_wen), 1);
         chk("post-abort busy", int'(busy), 0);
         chk("post-abort done", int'(done), 0);
      end else begin
         @(posedge clk); #1;
         start = 1'b0;
         chk("trace drained", exp_q.size(), 0);
      end
   endtask

   initial begin
      logic [10:0] wrap_exp[4];
      reset       = 1'b1;
      start       = 1'b0;
      num_pass    = '0;
      num_rows    = '0;
      base_addr   = '0;
      act_leaky   = 1'b0;
      ofifo_valid = 1'b0;
      st_at       = 0;
      st_len      = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset cen", int'(sram_cen), 1);
      chk("reset wen", int'(sram_wen), 1);
      chk("reset addr", int'(sram_addr), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset rd", int'(ofifo_rd), 0);

      run_tile(1, 4, 'h10, 0, 0, 0, 0, 0);
      chk("t1 model done", model_done, 13);
      chk("t1 done cycle", dut_done_cyc, 13);
      chk("t1 writes", wr_cnt, 8);
      for (int i = 0; i < 4; i++)
         chk("t1 pass addr", (wr_q.size() > i) ? int'(wr_q[i]) : -1, 'h10 + i);

      run_tile(3, 2, 'h100, 0, 0, 0, 0, 3);
      chk("t2 pops", rd_cnt, 6);
      chk("t2 done cycle", dut_done_cyc, 15);
      chk("t2 writes", wr_cnt, 8);

      run_tile(2, 2, 'h20, 0, 3, 3, 0, 0);
      chk("t3 done cycle", dut_done_cyc, 14);
      chk("t3 writes", wr_cnt, 6);
      chk("t3 cen low", cen_low_cnt, 10);

      run_tile(1, 4, 'h7FE, 0, 0, 0, 0, 0);
      wrap_exp[0] = 11'h7FE;
      wrap_exp[1] = 11'h7FF;
      wrap_exp[2] = 11'h000;
      wrap_exp[3] = 11'h001;
      for (int i = 0; i < 4; i++)
         chk("t4 wrap addr", (wr_q.size() > i) ? int'(wr_q[i]) : -1, int'(wrap_exp[i]));

      run_tile(2, 2, 'h30, 0, 0, 0, 4, 0);
      run_tile(2, 2, 'h30, 0, 0, 0, 0, 0);
      chk("t5 rerun done", dut_done_cyc, 11);

      run_tile(1, 2, 'h40, 1, 0, 0, 0, 0);
`ifdef SFP_LEAKY_EN
      chk("t6 actfunc", int'(af_seen), 1);
`else
      chk("t6 actfunc", int'(af_seen), 0);
`endif
      run_tile(2, 0, 'h50, 0, 0, 0, 0, 0);
      chk("t6 zero-row done", dut_done_cyc, 2);
      chk("t6 zero-row cen", cen_low_cnt, 0);

      run_tile(0, 3, 'h60, 0, 0, 0, 0, 0);
      chk("pass0 done", dut_done_cyc, 10);
      chk("pass0 pops", rd_cnt, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
